// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the one-bit-per-clock UART transmitter.
// Parity support is enabled by defining UART_TX_PARITY_EN.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;
   localparam logic START_BIT   = 1'b0;
   localparam logic STOP_BIT    = 1'b1;

   // Per-frame parity settings captured alongside the payload
   typedef struct packed {
      logic parity_type;
      logic parity_enable;
   } tx_cfg_t;

endpackage

// File: rtl/uart_tx_if.sv
// Request/serial-line bundle between a client and the UART transmitter.
interface uart_tx_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  data_valid;
   logic [DATA_WIDTH-1:0] parallel_data;
   logic                  parity_type;
   logic                  parity_enable;
   logic                  serial_data_out;
   logic                  busy;

   modport master (
      output data_valid, parallel_data, parity_type, parity_enable,
      input  serial_data_out, busy
   );

   modport slave (
      input  data_valid, parallel_data, parity_type, parity_enable,
      output serial_data_out, busy
   );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Parity bit for a data word: even = XOR of the bits, odd = XNOR of the bits.
module uart_tx_parity_calc
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  parity_type,
   output logic                  parity_c
);

   assign parity_c = (parity_type == PARITY_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_transmitter.sv
// One-bit-per-clock UART frame serialiser: start, data LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to include the parity bit; otherwise parity inputs are ignored.
module uart_transmitter
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   uart_tx_if.slave   bus
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
   tx_cfg_t cfg_q, cfg_d;
   logic    parity_c;

   uart_tx_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data        (data_q),
      .parity_type (cfg_q.parity_type),
      .parity_c    (parity_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
      end
   end
`else
   logic unused_parity_inputs;
   assign unused_parity_inputs = bus.parity_type ^ bus.parity_enable;
`endif

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Outputs are computed for the state being entered, so the line changes on the same edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
      cfg_d   = cfg_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d   = STOP_BIT;
            busy_d = 1'b0;
            if (bus.data_valid) begin
               data_d  = bus.parallel_data;
`ifdef UART_TX_PARITY_EN
               cfg_d.parity_type   = bus.parity_type;
               cfg_d.parity_enable = bus.parity_enable;
`endif
               state_d = START;
               tx_d    = START_BIT;
               busy_d  = 1'b1;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
            tx_d    = data_q[0];
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
`ifdef UART_TX_PARITY_EN
               if (cfg_q.parity_enable) begin
                  state_d = PARITY;
                  tx_d    = parity_c;
               end else begin
                  state_d = STOP;
                  tx_d    = STOP_BIT;
               end
`else
               state_d = STOP;
               tx_d    = STOP_BIT;
`endif
            end else begin
               cnt_d = cnt_inc;
               tx_d  = data_q[cnt_inc];
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            state_d = STOP;
            tx_d    = STOP_BIT;
         end
`endif
         STOP: begin
            state_d = IDLE;
            tx_d    = STOP_BIT;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = STOP_BIT;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         tx_q    <= STOP_BIT;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.serial_data_out = tx_q;
   assign bus.busy            = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter; honours UART_TX_PARITY_EN when expecting parity bits.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
   localparam bit PARITY_ON = 1'b1;
`else
   localparam bit PARITY_ON = 1'b0;
`endif

   typedef struct {
      logic [15:0] bits;
      int          len;
      int          start;
   } frame_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_errors;
   int   free_cycle;
   frame_t sb[$];
   bit   mon_active;

   uart_tx_if #(.DATA_WIDTH(8)) bus ();

   uart_transmitter #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected frame built from the bit-level definition of a UART frame
   function automatic frame_t model(logic [7:0] d, logic pt, logic pe);
      frame_t f;
      int     ones;
      logic   p;
      f.bits  = '0;
      f.len   = 0;
      f.start = 0;
      f.bits[f.len] = 1'b0;
      f.len++;
      for (int i = 0; i < 8; i++) begin
         f.bits[f.len] = d[i];
         f.len++;
      end
      ones = $countones(d);
      p = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      if (PARITY_ON && pe) begin
         f.bits[f.len] = p;
         f.len++;
      end
      f.bits[f.len] = 1'b1;
      f.len++;
      return f;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Apply inputs for the upcoming edge and decide, from frame timing, whether it is accepted
   task automatic apply(logic dv, logic [7:0] d, logic pt, logic pe);
      frame_t f;
      int     c;
      bus.data_valid    = dv;
      bus.parallel_data = d;
      bus.parity_type   = pt;
      bus.parity_enable = pe;
      c = cyc + 1;
      if (dv && c >= free_cycle) begin
         f = model(d, pt, pe);
         f.start = c;
         sb.push_back(f);
         free_cycle = c + f.len + 1;
      end
   endtask

   task automatic step(logic dv, logic [7:0] d, logic pt, logic pe);
      @(negedge clk);
      apply(dv, d, pt, pe);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // Monitor: pops a frame when busy rises and compares every bit and the frame length
   initial begin
      frame_t cur;
      int     idx;
      mon_active = 1'b0;
      idx = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mon_active = 1'b0;
         end else if (bus.busy) begin
            if (!mon_active) begin
               if (sb.size() == 0) begin
                  check("unexpected_frame", 32'(bus.busy), 32'd0);
               end else begin
                  cur = sb.pop_front();
                  mon_active = 1'b1;
                  idx = 0;
                  check("frame_start_cycle", 32'(cyc), 32'(cur.start));
               end
            end
            if (mon_active) begin
               if (idx >= cur.len) begin
                  check("frame_too_long", 32'(idx), 32'(cur.len));
               end else begin
                  check($sformatf("bit%0d", idx), 32'(bus.serial_data_out),
                        32'(cur.bits[idx]));
               end
               idx++;
            end
         end else begin
            check("idle_line", 32'(bus.serial_data_out), 32'd1);
            if (mon_active) begin
               check("frame_length", 32'(idx), 32'(cur.len));
               mon_active = 1'b0;
            end
         end
      end
   end

   initial begin
      cyc        = 0;
      n_checks   = 0;
      n_errors   = 0;
      free_cycle = 0;
      reset      = 1'b0;
      bus.data_valid    = 1'b0;
      bus.parallel_data = '0;
      bus.parity_type   = 1'b0;
      bus.parity_enable = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_line", 32'(bus.serial_data_out), 32'd1);
      check("reset_busy", 32'(bus.busy), 32'd0);

      // Release reset with a request already present: first edge must accept it
      @(negedge clk);
      reset = 1'b1;
      apply(1'b1, 8'hE6, 1'b0, 1'b1);
      idle(13);
      step(1'b1, 8'hFF, 1'b1, 1'b1);
      idle(13);
      step(1'b1, 8'hF4, 1'b0, 1'b0);
      idle(12);

      // Mid-frame request with different inputs is dropped
      step(1'b1, 8'hE6, 1'b1, 1'b1);
      idle(3);
      step(1'b1, 8'h00, 1'b0, 1'b0);
      idle(12);

      // Reset pulse while shifting data bits
      step(1'b1, 8'hA5, 1'b0, 1'b1);
      idle(4);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_reset_line", 32'(bus.serial_data_out), 32'd1);
      check("async_reset_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      sb.delete();
      free_cycle = 0;
      bus.data_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      apply(1'b1, 8'h3C, 1'b1, 1'b1);
      idle(13);

      // Random requests, many landing mid-frame
      for (int i = 0; i < 300; i++)
         step(($urandom % 4) == 0, 8'($urandom), 1'($urandom), 1'($urandom));

      // Continuous request: frames separated by exactly one idle cycle
      for (int i = 0; i < 40; i++)
         step(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
      idle(1);

      for (int i = 0; i < 40 && (sb.size() != 0 || mon_active); i++)
         @(negedge clk);
      check("drain_pending", 32'(sb.size()), 32'd0);
      check("drain_active", 32'(mon_active), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload bits per frame.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-005 parity_enable  input  1  1 = frame carries a parity bit.
REQ-006 data_valid  input  1  request to transmit parallel_data.
REQ-007 parallel_data  input  DATA_WIDTH  payload word.
REQ-008 serial_data_out  output  1  serial line, registered; idle level 1.
REQ-009 busy  output  1  high while a frame is in progress, registered.

Function
REQ-010 States SHALL be: IDLE, START, DATA, PARITY, STOP; one bit per clock cycle, with no baud divider.
REQ-011 In IDLE, serial_data_out SHALL be 1 and busy SHALL be 0.
REQ-012 A rising edge with data_valid=1 in IDLE SHALL capture parallel_data, parity_type and parity_enable into internal registers and enter START.
REQ-013 On that same edge, serial_data_out SHALL become 0 (start bit) and busy SHALL become 1, giving a latency of 1 cycle from data_valid to the start bit.
REQ-014 DATA SHALL output the captured word LSB first, DATA_WIDTH cycles, one bit per edge.
REQ-015 If the captured parity_enable is 1, PARITY SHALL output the parity bit for 1 cycle: even = XOR of the data bits; odd = XNOR of the data bits.
REQ-016 If the captured parity_enable is 0, the PARITY state SHALL be skipped.
REQ-017 STOP SHALL output 1 for 1 cycle.
REQ-018 The next edge after STOP SHALL return the block to IDLE with busy=0.
REQ-019 Frame length SHALL be DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 cycles without parity.
REQ-020 data_valid SHALL be ignored in every state except IDLE; a request during a frame is dropped, not queued.
REQ-021 Changes to the inputs during a frame SHALL NOT affect that frame, because only the captured copies are used.
REQ-022 The minimum request spacing SHALL be one IDLE cycle after STOP (back-to-back frames need data_valid in IDLE).
REQ-023 The internal bit counter SHALL run from 0 to DATA_WIDTH-1 and clear on leaving DATA, with no wrap into the next frame.

Reset
REQ-024 Asserting reset (low) SHALL, asynchronously: force IDLE, set serial_data_out=1, set busy=0, and clear the counter and capture registers.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; transmission resumes only on a new data_valid after release.
REQ-026 The first accepted data_valid SHALL be the one present on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: parity behaviour SHALL be as in REQ-015 and REQ-016.
REQ-028 Macro UART_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be compiled out.
REQ-029 With UART_TX_PARITY_EN undefined, the parity_type and parity_enable ports SHALL remain but be ignored, and every frame SHALL be start+data+stop.

Structure
REQ-030 Shared package uart_tx_pkg SHALL hold the state enum typedef, the parity-type constants (EVEN=0, ODD=1), and the START_BIT=0 / STOP_BIT=1 constants.
REQ-031 One sub-module, uart_tx_parity_calc, SHALL compute the parity bit from the data word and parity_type.
REQ-032 The FSM, counter and output mux SHALL reside in uart_transmitter.

Verification (macro defined, DATA_WIDTH=8, sample one bit per cycle starting the cycle after data_valid)
REQ-033 Even parity: data 0xE6, parity_enable=1, parity_type=0 -> bits 0, 0,1,1,0,0,1,1,1, 1(parity), 1(stop), with busy high for 11 cycles.
REQ-034 Odd parity: data 0xFF, parity_enable=1, parity_type=1 -> bits 0, eight 1s, 1(parity), 1(stop).
REQ-035 No parity: data 0xF4, parity_enable=0 -> bits 0, 0,0,1,0,1,1,1,1, 1(stop), then IDLE with busy=0 after 10 cycles.
REQ-036 data_valid=1 with data 0x00 asserted mid-frame -> current frame unchanged and no second frame starts.
REQ-037 Reset pulsed during DATA -> serial_data_out=1 and busy=0 immediately; the next data_valid produces a clean full frame.
REQ-038 Macro undefined, data 0xE6, parity_enable=1 -> 10-cycle frame with no parity bit.
